// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio frame buffer:
//   - default sample width and channel count
//   - channel-select encodings
//   - ping-pong buffer states and read-side FSM states
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH  = 24;
    localparam int AUDIO_CHANNEL_NUM = 2;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_MONO  = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_READING = 2'd3
    } buf_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

endpackage

// File: rtl/audio_rdy_sync.sv
// ----------------------------------------------------------------------------
// audio_rdy_sync
// Brings the receiver's asynchronous ready level into the iCLK domain through
// two flops and produces a one-cycle pulse on its rising edge.
// Ports:
//   iCLK    system clock
//   iRST    synchronous active-high reset (all flops clear to 0)
//   iRDY    asynchronous ready level
//   oPULSE  one-cycle pulse, high in the cycle the synchronised edge is seen
// ----------------------------------------------------------------------------
module audio_rdy_sync
    import audio_pkg::*;
(
    input  logic iCLK,
    input  logic iRST,
    input  logic iRDY,
    output logic oPULSE
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= iRDY;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign oPULSE = r_sync2 & ~r_prev;

endmodule

// File: rtl/audio_frame_buffer.sv
// ----------------------------------------------------------------------------
// audio_frame_buffer
// Captures stereo samples from the audio receiver, selects/mixes one channel,
// gathers FRAME_LEN samples into one half of a ping-pong memory and streams
// each complete frame out over valid/ready with SOP/EOP markers.
// Ports:
//   iCLK, iRST      system clock, synchronous active-high reset
//   iRDY            asynchronous sample-ready level from the receiver
//   iSAMPLE[0:N-1]  packed stereo sample, index 0 = left MSB
//   oDATA           frame sample (signed, [DW-1:0]), zero when not valid
//   oVALID/iREADY   stream handshake
//   oSOP/oEOP       first / last word of a frame
//   oOVERFLOW       sticky flag: at least one sample was dropped
//   oDROP_CNT       saturating count of dropped samples
// ----------------------------------------------------------------------------
module audio_frame_buffer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int CHANNEL_NUM = AUDIO_CHANNEL_NUM,
    parameter int FRAME_LEN   = 256,
    parameter int CHANNEL_SEL = CH_LEFT
)(
    input  logic                              iCLK,
    input  logic                              iRST,
    input  logic                              iRDY,
    input  logic [0:DATA_WIDTH*CHANNEL_NUM-1] iSAMPLE,
    output logic [DATA_WIDTH-1:0]             oDATA,
    output logic                              oVALID,
    input  logic                              iREADY,
    output logic                              oSOP,
    output logic                              oEOP,
    output logic                              oOVERFLOW,
    output logic [15:0]                       oDROP_CNT
);

    localparam int            AW       = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    // ---------------- capture and channel select ----------------
    logic w_capture;

    audio_rdy_sync u_rdy_sync (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iRDY   (iRDY),
        .oPULSE (w_capture)
    );

    logic        [DATA_WIDTH-1:0] w_left;
    logic        [DATA_WIDTH-1:0] w_right;
    logic        [DATA_WIDTH-1:0] w_sample;
    logic signed [DATA_WIDTH:0]   w_sum;

    // Incoming fields are first-bit-MSB; remap into conventional [DW-1:0].
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_unpack
            assign w_left[DATA_WIDTH-1-gi]  = iSAMPLE[gi];
            assign w_right[DATA_WIDTH-1-gi] = iSAMPLE[DATA_WIDTH+gi];
        end
    endgenerate

    // One guard bit keeps the sum exact; the arithmetic shift floors.
    assign w_sum = signed'({w_left[DATA_WIDTH-1], w_left}) +
                   signed'({w_right[DATA_WIDTH-1], w_right});

    always_comb begin
        case (CHANNEL_SEL)
            CH_RIGHT: w_sample = w_right;
            CH_MONO:  w_sample = DATA_WIDTH'(w_sum >>> 1);
            default:  w_sample = w_left;
        endcase
    end

    // ---------------- shared state ----------------
    buf_state_t      r_buf_state [2];
    rd_state_t       r_rd_state;
    rd_state_t       w_rd_state_next;
    logic            r_rd_buf;
    logic [AW-1:0]   r_rd_ptr;
    logic            r_wr_buf;
    logic [AW-1:0]   r_wr_ptr;
    logic            r_wr_wait;
    logic            r_older;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;
    logic [DATA_WIDTH-1:0] r_mem [0:2*FRAME_LEN-1];
    logic [DATA_WIDTH-1:0] r_rd_q;

    logic [1:0]      w_full;
    logic            w_pick;
    logic            w_accept;
    logic            w_rd_last;
    logic            w_release;
    logic            w_claim;
    logic            w_claim_buf;
    logic            w_wr_target;
    logic            w_wr_en;
    logic            w_wr_last;
    logic            w_other_empty;
    logic            w_drop;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_ptr_fetch;
    logic [AW:0]     w_rd_addr;

    assign w_full    = {r_buf_state[1] == BUF_FULL, r_buf_state[0] == BUF_FULL};
    // Both FULL: the older one goes first; otherwise take whichever is FULL.
    assign w_pick    = (&w_full) ? r_older : w_full[1];
    assign w_accept  = oVALID & iREADY;
    assign w_rd_last = (r_rd_ptr == LAST_IDX);
    assign w_release = w_accept & w_rd_last;

    always_comb begin
        w_claim     = 1'b0;
        w_claim_buf = w_pick;
        if (r_rd_state == RD_IDLE && (|w_full)) begin
            w_claim = 1'b1;
        end else if (w_release && w_full[~r_rd_buf]) begin
            w_claim     = 1'b1;
            w_claim_buf = ~r_rd_buf;
        end
    end

    // ---------------- write side ----------------
    // While waiting, the only buffer that can free up is the one being read,
    // and a sample arriving in that same cycle lands at its index 0.
    assign w_wr_target   = r_wr_wait ? r_rd_buf : r_wr_buf;
    assign w_wr_en       = w_capture & (~r_wr_wait | w_release);
    assign w_wr_last     = (r_wr_ptr == LAST_IDX);
    assign w_other_empty = (r_buf_state[~w_wr_target] == BUF_EMPTY) ||
                           (w_release && (r_rd_buf == ~w_wr_target));
    assign w_drop        = w_capture & r_wr_wait & ~w_release;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wr_buf  <= 1'b0;
            r_wr_ptr  <= '0;
            r_wr_wait <= 1'b0;
            r_older   <= 1'b0;
        end else begin
            if (r_wr_wait && w_release) begin
                r_wr_wait <= 1'b0;
                r_wr_buf  <= r_rd_buf;
            end
            if (w_wr_en) begin
                if (w_wr_last) begin
                    r_wr_ptr <= '0;
                    if (r_buf_state[~w_wr_target] != BUF_FULL)
                        r_older <= w_wr_target;
                    if (w_other_empty) begin
                        r_wr_buf <= ~w_wr_target;
                    end else begin
                        r_wr_buf  <= w_wr_target;
                        r_wr_wait <= 1'b1;
                    end
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_wr_buf <= w_wr_target;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Reader updates first; a writer claim on the same buffer in the same
    // cycle (refill starting right after release) takes precedence.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int b = 0; b < 2; b++)
                r_buf_state[b] <= BUF_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_claim && w_claim_buf == 1'(b))
                    r_buf_state[b] <= BUF_READING;
                if (w_release && r_rd_buf == 1'(b))
                    r_buf_state[b] <= BUF_EMPTY;
                if (w_wr_en && w_wr_target == 1'(b))
                    r_buf_state[b] <= w_wr_last ? BUF_FULL : BUF_FILLING;
            end
        end
    end

    // ---------------- read side FSM ----------------
    always_ff @(posedge iCLK) begin
        if (iRST)
            r_rd_state <= RD_IDLE;
        else
            r_rd_state <= w_rd_state_next;
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:   if (|w_full) w_rd_state_next = RD_LOAD;
            RD_LOAD:   w_rd_state_next = RD_STREAM;
            RD_STREAM: if (w_release)
                           w_rd_state_next = w_full[~r_rd_buf] ? RD_LOAD : RD_IDLE;
            default:   w_rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        oVALID = (r_rd_state == RD_STREAM);
        oSOP   = oVALID && (r_rd_ptr == '0);
        oEOP   = oVALID && w_rd_last;
        oDATA  = oVALID ? r_rd_q : '0;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_rd_buf <= 1'b0;
            r_rd_ptr <= '0;
        end else if (w_claim) begin
            r_rd_buf <= w_claim_buf;
            r_rd_ptr <= '0;
        end else if (w_accept && !w_rd_last) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // ---------------- ping-pong memory ----------------
    // The read register doubles as the output word: it only reloads on LOAD
    // or on an accepted non-final word, so oDATA holds during stalls and the
    // next word is ready the cycle after an accept.
    assign w_rd_en        = (r_rd_state == RD_LOAD) || (w_accept && !w_rd_last);
    assign w_rd_ptr_fetch = (r_rd_state == RD_LOAD) ? r_rd_ptr : r_rd_ptr + AW'(1);
    assign w_rd_addr      = {r_rd_buf, w_rd_ptr_fetch};

    always_ff @(posedge iCLK) begin
        if (w_wr_en)
            r_mem[{w_wr_target, r_wr_ptr}] <= w_sample;
        if (w_rd_en)
            r_rd_q <= r_mem[w_rd_addr];
    end

    assign oOVERFLOW = r_overflow;
    assign oDROP_CNT = r_drop_cnt;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// ----------------------------------------------------------------------------
// tb_audio_frame_buffer
// Directed bench: one left-channel instance and one mono instance share all
// inputs. Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_audio_frame_buffer;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ready;
    logic [0:47] sample;

    logic [23:0] d0, dm;
    logic        v0, s0, e0, o0;
    logic        vm, sm, em, om;
    logic [15:0] c0, cm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    audio_frame_buffer #(.DATA_WIDTH(24), .CHANNEL_NUM(2), .FRAME_LEN(FL), .CHANNEL_SEL(0)) u_dut (
        .iCLK(clk), .iRST(rst), .iRDY(rdy), .iSAMPLE(sample),
        .oDATA(d0), .oVALID(v0), .iREADY(ready), .oSOP(s0), .oEOP(e0),
        .oOVERFLOW(o0), .oDROP_CNT(c0)
    );

    audio_frame_buffer #(.DATA_WIDTH(24), .CHANNEL_NUM(2), .FRAME_LEN(FL), .CHANNEL_SEL(2)) u_mono (
        .iCLK(clk), .iRST(rst), .iRDY(rdy), .iSAMPLE(sample),
        .oDATA(dm), .oVALID(vm), .iREADY(ready), .oSOP(sm), .oEOP(em),
        .oOVERFLOW(om), .oDROP_CNT(cm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // First received bit (index 0) is the MSB of each field.
    function automatic logic [0:47] pack(input logic [23:0] l, input logic [23:0] r);
        logic [0:47] s;
        for (int k = 0; k < 24; k++) begin
            s[k]      = l[23-k];
            s[24 + k] = r[23-k];
        end
        return s;
    endfunction

    // Called at a falling edge; returns at a falling edge 4 cycles later.
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        sample = pack(l, r);
        rdy    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_valid"}, v0, 0);
        check({tag, "_sop"},   s0, 0);
        check({tag, "_eop"},   e0, 0);
        check({tag, "_ovf"},   o0, 0);
        check({tag, "_cnt"},   c0, 0);
        check({tag, "_data"},  d0, 0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!v0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, v0, 1);
    endtask

    // Reads one word with iREADY high; accepted at the next rising edge.
    task automatic read_word(input string tag, input logic [23:0] exp, input logic sop, input logic eop);
        wait_valid(tag);
        check({tag, "_data"}, d0, exp);
        check({tag, "_sop"},  s0, sop);
        check({tag, "_eop"},  e0, eop);
        $display("[TB] %s data=0x%06h sop=%0b eop=%0b", tag, d0, s0, e0);
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        rdy    = 1'b0;
        ready  = 1'b0;
        sample = '0;
        @(negedge clk);

        // ---- reset state ----
        do_reset("rst0");

        // ---- left channel, streaming back-to-back ----
        ready = 1'b1;
        for (int k = 1; k <= FL; k++) send(24'(k), 24'h0);
        wait_valid("t1_start");
        for (int i = 0; i < FL; i++) begin
            check("t1_valid", v0, 1);
            check("t1_data",  d0, 32'(i + 1));
            check("t1_sop",   s0, (i == 0));
            check("t1_eop",   e0, (i == FL - 1));
            check("t1_mono",  dm, 32'((i + 1) / 2));
            $display("[TB] t1 word %0d data=0x%06h sop=%0b eop=%0b", i, d0, s0, e0);
            @(negedge clk);
        end
        check("t1_ovf",  o0, 0);
        check("t1_idle", v0, 0);

        // ---- mono mixing boundaries ----
        do_reset("rst1");
        send(24'h7FFFFF, 24'h000001);
        send(24'h800000, 24'h7FFFFF);
        for (int k = 3; k <= FL; k++) send(24'(k), 24'(k));
        wait_valid("t2_start");
        check("t2_mono0", dm, 32'h400000);
        check("t2_left0", d0, 32'h7FFFFF);
        check("t2_sop",   sm, 1);
        $display("[TB] t2 word 0 mono=0x%06h", dm);
        @(negedge clk);
        check("t2_mono1", dm, 32'hFFFFFF);
        check("t2_left1", d0, 32'h800000);
        $display("[TB] t2 word 1 mono=0x%06h", dm);
        @(negedge clk);
        for (int k = 3; k <= FL; k++) begin
            check("t2_monok", dm, 32'(k));
            @(negedge clk);
        end

        // ---- overflow with the FFT stalled ----
        do_reset("rst2");
        ready = 1'b0;
        for (int k = 1; k <= 3 * FL; k++) send(24'(k), 24'h0);
        check("t3_ovf",   o0, 1);
        check("t3_cnt",   c0, FL);
        check("t3_valid", v0, 1);
        check("t3_hold",  d0, 1);
        check("t3_sop",   s0, 1);
        ready = 1'b1;
        for (int k = 1; k <= 2 * FL; k++)
            read_word("t3_word", 24'(k), (k == 1 || k == FL + 1), (k == FL || k == 2 * FL));
        repeat (6) @(negedge clk);
        check("t3_nomore", v0, 0);
        check("t3_cnt_kept", c0, FL);

        // ---- random backpressure ----
        do_reset("rst3");
        ready = 1'b0;
        for (int k = 0; k < FL; k++) send(24'(32'h100 + k), 24'h0);
        wait_valid("t4_start");
        begin
            int          idx  = 0;
            int          cyc  = 0;
            logic        held = 1'b0;
            logic [23:0] pd   = '0;
            logic        ps   = 1'b0;
            logic        pe   = 1'b0;
            logic        r;
            while (idx < FL && cyc < 200) begin
                check("t4_valid", v0, 1);
                check("t4_data",  d0, 32'h100 + idx);
                check("t4_sop",   s0, (idx == 0));
                check("t4_eop",   e0, (idx == FL - 1));
                if (held) begin
                    check("t4_hold_data", d0, pd);
                    check("t4_hold_sop",  s0, ps);
                    check("t4_hold_eop",  e0, pe);
                end
                pd = d0; ps = s0; pe = e0;
                r = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                ready = r;
                held  = v0 & ~r;
                if (v0 && r) begin
                    $display("[TB] t4 accept %0d data=0x%06h", idx, d0);
                    idx++;
                end
                cyc++;
                @(negedge clk);
            end
            check("t4_count", idx, FL);
        end
        ready = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_idle", v0, 0);

        // ---- reset while active, then mid-frame ----
        for (int k = 1; k <= 2 * FL + 1; k++) send(24'(k), 24'h0);
        check("t5_ovf", o0, 1);
        check("t5_cnt", c0, 1);
        do_reset("rst4");
        ready = 1'b1;
        for (int k = 0; k < 4; k++) send(24'(32'h50 + k), 24'h0);
        // Fifth sample: reset lands on its capture edge, so it is lost.
        sample = pack(24'h000054, 24'h0);
        rdy    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        do_reset("rst5");
        @(negedge clk);
        check("t5_partial", v0, 0);
        for (int k = 0; k < FL; k++) send(24'(32'h60 + k), 24'h0);
        for (int k = 0; k < FL; k++)
            read_word("t5_word", 24'(32'h60 + k), (k == 0), (k == FL - 1));
        repeat (6) @(negedge clk);
        check("t5_nomore", v0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
- Sits directly downstream of the audio serial receiver in the FFT test design.
- Consumes its 48-bit parallel stereo sample and asynchronous ready level, and moves them into the system clock domain.
- Selects or mixes one channel and collects FRAME_LEN samples into a ping-pong buffer.
- Streams each completed frame to the FFT core over a valid/ready interface, with start- and end-of-packet markers.

Parameters:
- DATA_WIDTH, 24, bits per channel sample (two's complement).
- CHANNEL_NUM, 2, channels packed in iSAMPLE.
- FRAME_LEN, 256, samples per FFT frame (power of 2, 8..1024).
- CHANNEL_SEL, 0, 0 = left, 1 = right, 2 = mono average of left and right.

Ports:
- iCLK  in  1  system clock; all logic is on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- iRDY  in  1  sample-ready level from the receiver; asynchronous to iCLK.
- iSAMPLE  in  DATA_WIDTH*CHANNEL_NUM  packed sample, declared [0:47]. Index 0 is the first received bit, which is the left-channel MSB. Left = [0:23], right = [24:47], MSB at the lower index.
- oDATA  out  DATA_WIDTH  frame sample, normal [23:0] order, signed.
- oVALID  out  1  oDATA is valid.
- iREADY  in  1  FFT accepts oDATA.
- oSOP  out  1  first sample of a frame; qualified by oVALID.
- oEOP  out  1  last sample of a frame; qualified by oVALID.
- oOVERFLOW  out  1  sticky; a sample was dropped. Cleared only by iRST.
- oDROP_CNT  out  16  count of dropped samples; saturates at 0xFFFF.

Behaviour:
- Reset: on iRST=1 at a clock edge, all flags, pointers and both buffer states are cleared and buffered data is discarded. On the next cycle: oVALID=0, oSOP=0, oEOP=0, oOVERFLOW=0, oDROP_CNT=0, oDATA=0. The synchroniser flops reset to 0.
- Capture:
  - iRDY passes through a 2-flop synchroniser, then a rising-edge detect.
  - iSAMPLE is captured in the cycle the edge is detected. It is stable there because the receiver only changes it when asserting RDY.
  - Latency from iRDY rising to capture: 3 iCLK cycles. iRDY high pulses must be at least 2 iCLK periods wide.
- Channel select:
  - CHANNEL_SEL 0 or 1: the chosen 24-bit field is bit-reversed into [23:0] order.
  - CHANNEL_SEL 2: left and right are sign-extended to 25 bits, added, then arithmetic-shifted right by 1 (round toward negative infinity).
- Write side, per buffer state:
  - Each buffer is EMPTY, FILLING, FULL or READING.
  - The write pointer increments 0..FRAME_LEN-1 on each captured sample.
  - At FRAME_LEN-1 the buffer becomes FULL. The writer then moves to the other buffer if it is EMPTY; otherwise it enters WAIT.
  - In WAIT, each captured sample is dropped: oOVERFLOW is set and oDROP_CNT increments.
  - The writer leaves WAIT in the cycle a buffer becomes EMPTY. The next sample goes to index 0 of that buffer.
  - A partial frame is never emitted.
- Read side FSM:
  - IDLE to LOAD: a FULL buffer exists. When both are FULL, the older one is taken first.
  - LOAD (1 cycle, memory read latency) to STREAM.
  - STREAM: oVALID=1. oDATA, oSOP and oEOP are held stable while iREADY=0.
  - On oVALID & iREADY the read pointer advances, and the next word appears on the following cycle with no bubble (prefetch register).
  - oSOP=1 at read index 0; oEOP=1 at index FRAME_LEN-1.
  - Accepting the EOP word marks the buffer EMPTY and returns to IDLE. If the other buffer is already FULL, the FSM goes straight to LOAD.
- Simultaneous events:
  - A buffer released by the reader in the same cycle the writer completes a fill counts as EMPTY for the writer in that cycle. No drop occurs.
  - A capture coinciding with iRST is discarded.
- Throughput: sustains iREADY held high continuously. The FFT may stall indefinitely; loss occurs only through the overflow path.

Decomposition:
- Package audio_pkg holds:
  - DATA_WIDTH and CHANNEL_NUM defaults;
  - CHANNEL_SEL encodings (CH_LEFT=0, CH_RIGHT=1, CH_MONO=2);
  - buffer-state and read-FSM state encodings.
- One sub-module, audio_rdy_sync: 2-flop synchroniser plus rising-edge pulse, with iCLK and iRST.
- The ping-pong memory is inferred in the top level, 2*FRAME_LEN x DATA_WIDTH.

Test Plan:
- CHANNEL_SEL=0, FRAME_LEN=8; send 8 RDY pulses with left fields 1..8 (first-bit-MSB packing); iREADY=1 -> oDATA 1..8 on 8 consecutive cycles, oSOP with 1, oEOP with 8, oOVERFLOW=0.
- CHANNEL_SEL=2; left=0x7FFFFF, right=0x000001 -> 0x400000. Left=0x800000, right=0x7FFFFF -> 0xFFFFFF (-1).
- iREADY=0 held; send 3*FRAME_LEN samples -> first 2 frames are stored intact. The third frame's FRAME_LEN samples are dropped: oOVERFLOW=1, oDROP_CNT=FRAME_LEN. Releasing iREADY then emits frame 1 then frame 2 in order.
- Toggle iREADY randomly during STREAM -> oDATA/oSOP/oEOP never change while oVALID & !iREADY; no sample is skipped or duplicated.
- Assert iRST for 1 cycle mid-frame (index 4 of 8) -> next cycle all outputs are 0. The next 8 samples form a fresh frame starting with oSOP on the first post-reset sample.
